// File: rtl/dffram_param_clr.sv
// Parametrised single-port DFF RAM with byte enables, a hardware clear sweep
// and an optional output register; READY is low while the array is cleared.
module dffram_param_clr #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int OUT_REG = 0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLR,
  output logic               READY,
  input  logic               EN0,
  input  logic [WIDTH/8-1:0] WE0,
  input  logic [AW-1:0]      A0,
  input  logic [WIDTH-1:0]   Di0,
  output logic [WIDTH-1:0]   Do0
);

  localparam int NB = WIDTH / 8;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [AW-1:0]    r_ptr;
  logic             r_ready;
  logic [WIDTH-1:0] r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_clr_we;
  logic             w_acc;
  logic             w_inr;
  logic [31:0]      w_a32;
  logic [WIDTH-1:0] w_rdata;

  // Out-of-range addresses must never alias onto real words.
  assign w_a32   = 32'(A0);
  assign w_inr   = w_a32 < 32'(DEPTH);
  assign w_rdata = w_inr ? r_mem[A0] : '0;

  always_comb begin
    w_nstate = r_state;
    w_clr_we = 1'b0;
    w_acc    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_ptr == LAST)
          w_nstate = S_IDLE;
      end
      S_IDLE: begin
        if (CLR)
          w_nstate = S_CLEAR;
        else
          w_acc = EN0;
      end
      default: w_nstate = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_ready <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_state <= w_nstate;
      r_rd    <= w_acc ? w_rdata : '0;
      if (r_state == S_CLEAR) begin
        r_ptr   <= r_ptr + 1'b1;
        r_ready <= (r_ptr == LAST);
      end else if (CLR) begin
        r_ptr   <= '0;
        r_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (w_clr_we) begin
        r_mem[r_ptr] <= '0;
      end else if (w_acc && w_inr) begin
        for (int i = 0; i < NB; i++)
          if (WE0[i])
            r_mem[A0][8*i +: 8] <= Di0[8*i +: 8];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] r_do;
      always_ff @(posedge CLK) begin
        if (RST || r_state == S_CLEAR)
          r_do <= '0;
        else
          r_do <= r_rd;
      end
      assign Do0 = r_do;
    end else begin : g_nreg
      assign Do0 = r_rd;
    end
  endgenerate

  assign READY = r_ready;

endmodule
